// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: final pipeline stage driving the register-file write port.
// Selects ALU / load / PC+4 writeback, waits for data-memory responses on loads
// with a bounded timeout, and aligns/extends load data by funct3.
// All write-port outputs are registered so they hold steady across the
// register file's negedge write.
module rf_writeback_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_reg_wr,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb_sel,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_pc4,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_wr,
    output logic [4:0]  rd,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        load_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT_MEM = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;

    // load context captured at accept, used when the response arrives
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_addr;

    logic        r_rf_wr;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;
    logic        r_load_err;

    logic        w_rf_wr_next;
    logic [4:0]  w_rd_next;
    logic [31:0] w_wdata_next;
    logic        w_load_err_next;

    logic        w_accept;
    logic        w_is_load;
    logic        w_misaligned;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign ex_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_WAIT_MEM);
    assign w_accept  = ex_valid && ex_ready;
    assign w_is_load = (ex_wb_sel == 2'b01);

    assign rf_wr    = r_rf_wr;
    assign rd       = r_rd;
    assign wdata    = r_wdata;
    assign load_err = r_load_err;

    // Detect misaligned halfword/word loads at accept time
    always_comb begin
        w_misaligned = 1'b0;
        case (ex_funct3)
            3'b001, 3'b101: w_misaligned = ex_alu_result[0];
            3'b010:         w_misaligned = |ex_alu_result[1:0];
            default:        w_misaligned = 1'b0;
        endcase
    end

    // Align the raw memory word and extend it according to the captured funct3
    assign w_shifted = dmem_rdata >> {r_ld_addr, 3'b000};
    always_comb begin
        w_load_data = dmem_rdata;
        case (r_ld_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // State register, timeout counter and load-context capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'h00;
            r_ld_rd     <= 5'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_addr   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept && w_is_load) begin
                r_ld_rd     <= ex_rd;
                r_ld_funct3 <= ex_funct3;
                r_ld_addr   <= ex_alu_result[1:0];
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_load && !w_misaligned) begin
                    w_state_next = S_WAIT_MEM;
                    w_cnt_next   = 8'h00;
                end
            end
            S_WAIT_MEM: begin
                if (dmem_rvalid) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_next = r_cnt + 8'h01;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: what the write port should show after the next edge
    always_comb begin
        w_rf_wr_next    = 1'b0;
        w_rd_next       = r_rd;
        w_wdata_next    = r_wdata;
        w_load_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_load) begin
                        w_rf_wr_next = ex_reg_wr && (ex_rd != 5'd0);
                        w_rd_next    = ex_rd;
                        w_wdata_next = (ex_wb_sel == 2'b10) ? ex_pc4 : ex_alu_result;
                    end else if (w_misaligned) begin
                        w_load_err_next = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (dmem_rvalid) begin
                    w_rf_wr_next = (r_ld_rd != 5'd0);
                    w_rd_next    = r_ld_rd;
                    w_wdata_next = w_load_data;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_load_err_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wr    <= 1'b0;
            r_rd       <= 5'd0;
            r_wdata    <= 32'h0;
            r_load_err <= 1'b0;
        end else begin
            r_rf_wr    <= w_rf_wr_next;
            r_rd       <= w_rd_next;
            r_wdata    <= w_wdata_next;
            r_load_err <= w_load_err_next;
        end
    end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed testbench for rf_writeback_unit with hand-computed expectations.
module tb_rf_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_wr;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_pc4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_wr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        busy;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    rf_writeback_unit #(.MEM_TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_reg_wr     (ex_reg_wr),
        .ex_rd         (ex_rd),
        .ex_wb_sel     (ex_wb_sel),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .ex_pc4        (ex_pc4),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .rf_wr         (rf_wr),
        .rd            (rd),
        .wdata         (wdata),
        .busy          (busy),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp_val, $time);
        end
    endtask

    // advance to 1 time unit after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [4:0] r, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
        ex_valid      = 1'b1;
        ex_reg_wr     = wr;
        ex_rd         = r;
        ex_wb_sel     = sel;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_pc4        = pc4;
    endtask

    // ALU/PC+4 writeback: accept, then check one cycle later
    task automatic do_simple(input string tag, input logic wr, input logic [4:0] r,
                             input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                             input logic exp_wr, input logic [31:0] exp_data);
        drive(wr, r, sel, 3'b000, alu, pc4);
        tick();
        ex_valid = 1'b0;
        chk({tag, ".rf_wr"}, {31'h0, rf_wr}, {31'h0, exp_wr});
        chk({tag, ".rd"},    {27'h0, rd}, {27'h0, r});
        chk({tag, ".wdata"}, wdata, exp_data);
        $display("txn %s rd=%0d wdata=0x%08h rf_wr=%0b", tag, rd, wdata, rf_wr);
    endtask

    // Load whose response arrives 'delay' cycles after the accept edge
    task automatic do_load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input int delay, input logic [31:0] exp_data);
        drive(1'b1, r, 2'b01, f3, addr, 32'h0);
        tick();
        ex_valid   = 1'b0;
        dmem_rdata = rdata;
        for (int i = 0; i < delay; i++) begin
            chk({tag, ".busy"},  {31'h0, busy}, 32'h1);
            chk({tag, ".ready"}, {31'h0, ex_ready}, 32'h0);
            chk({tag, ".nowr"},  {31'h0, rf_wr}, 32'h0);
            if (i == delay - 1) dmem_rvalid = 1'b1;
            tick();
        end
        dmem_rvalid = 1'b0;
        chk({tag, ".rf_wr"}, {31'h0, rf_wr}, 32'h1);
        chk({tag, ".rd"},    {27'h0, rd}, {27'h0, r});
        chk({tag, ".wdata"}, wdata, exp_data);
        chk({tag, ".busy0"}, {31'h0, busy}, 32'h0);
        chk({tag, ".err0"},  {31'h0, load_err}, 32'h0);
        $display("txn %s rd=%0d wdata=0x%08h rf_wr=%0b", tag, rd, wdata, rf_wr);
        tick();
        chk({tag, ".wr_drop"}, {31'h0, rf_wr}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_reg_wr = 1'b0; ex_rd = 5'd0; ex_wb_sel = 2'b00;
        ex_funct3 = 3'b000; ex_alu_result = 32'h0; ex_pc4 = 32'h0;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        tick();
        tick();
        chk("rst.rf_wr",    {31'h0, rf_wr}, 32'h0);
        chk("rst.rd",       {27'h0, rd}, 32'h0);
        chk("rst.wdata",    wdata, 32'h0);
        chk("rst.busy",     {31'h0, busy}, 32'h0);
        chk("rst.load_err", {31'h0, load_err}, 32'h0);
        chk("rst.ready",    {31'h0, ex_ready}, 32'h1);
        $display("txn reset released");
        rst_n = 1'b1;
        tick();

        // ALU writeback, then write enable drops
        do_simple("alu", 1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 1'b1, 32'hDEADBEEF);
        tick();
        chk("alu.wr_drop", {31'h0, rf_wr}, 32'h0);

        // Loads with alignment/extension
        do_load("lb",  5'd9,  3'b000, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        do_load("lbu", 5'd9,  3'b100, 32'h0000_1003, 32'h80FF_0000, 3, 32'h0000_0080);
        do_load("lhu", 5'd10, 3'b101, 32'h0000_2002, 32'hBEEF_1234, 1, 32'h0000_BEEF);
        do_load("lh",  5'd11, 3'b001, 32'h0000_2000, 32'h1234_8001, 2, 32'hFFFF_8001);
        do_load("lw",  5'd12, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        do_load("lb1", 5'd13, 3'b000, 32'h0000_0001, 32'h0000_7F00, 1, 32'h0000_007F);

        // JAL (PC+4), reserved select acts as ALU, reg_wr=0 suppresses write
        do_simple("jal",  1'b1, 5'd1, 2'b10, 32'h0000_0055, 32'h0000_0104, 1'b1, 32'h0000_0104);
        do_simple("sel3", 1'b1, 5'd2, 2'b11, 32'h1357_9BDF, 32'h0000_0200, 1'b1, 32'h1357_9BDF);
        do_simple("nowr", 1'b0, 5'd3, 2'b00, 32'h0000_00AA, 32'h0, 1'b0, 32'h0000_00AA);
        tick();

        // Misaligned LW: error pulse, no write, stays idle
        drive(1'b1, 5'd4, 2'b01, 3'b010, 32'h0000_3001, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("mis.load_err", {31'h0, load_err}, 32'h1);
        chk("mis.rf_wr",    {31'h0, rf_wr}, 32'h0);
        chk("mis.busy",     {31'h0, busy}, 32'h0);
        chk("mis.ready",    {31'h0, ex_ready}, 32'h1);
        $display("txn misaligned lw load_err=%0b", load_err);
        tick();
        chk("mis.err_drop", {31'h0, load_err}, 32'h0);

        // Misaligned LH
        drive(1'b1, 5'd4, 2'b01, 3'b001, 32'h0000_3003, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("mis_lh.load_err", {31'h0, load_err}, 32'h1);
        chk("mis_lh.busy",     {31'h0, busy}, 32'h0);
        $display("txn misaligned lh load_err=%0b", load_err);
        tick();

        // Timeout: error exactly 15 edges after entering WAIT_MEM
        drive(1'b1, 5'd6, 2'b01, 3'b010, 32'h0000_0040, 32'h0);
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk("tmo.busy", {31'h0, busy}, 32'h1);
            chk("tmo.early_err", {31'h0, load_err}, 32'h0);
            tick();
        end
        chk("tmo.busy14", {31'h0, busy}, 32'h1);
        tick();
        chk("tmo.load_err", {31'h0, load_err}, 32'h1);
        chk("tmo.rf_wr",    {31'h0, rf_wr}, 32'h0);
        chk("tmo.ready",    {31'h0, ex_ready}, 32'h1);
        $display("txn timeout load_err=%0b ready=%0b", load_err, ex_ready);
        tick();
        chk("tmo.err_drop", {31'h0, load_err}, 32'h0);

        // Stale response while idle is ignored
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        chk("stale.rf_wr", {31'h0, rf_wr}, 32'h0);
        chk("stale.busy",  {31'h0, busy}, 32'h0);
        $display("txn stale rvalid rf_wr=%0b", rf_wr);

        // Back-to-back to x0, x7, x0
        do_simple("b2b0", 1'b1, 5'd0, 2'b00, 32'h0000_0011, 32'h0, 1'b0, 32'h0000_0011);
        do_simple("b2b7", 1'b1, 5'd7, 2'b00, 32'h0000_0022, 32'h0, 1'b1, 32'h0000_0022);
        do_simple("b2b0b",1'b1, 5'd0, 2'b00, 32'h0000_0033, 32'h0, 1'b0, 32'h0000_0033);

        // Load to x0 completes without a write
        drive(1'b1, 5'd0, 2'b01, 3'b010, 32'h0000_0020, 32'h0);
        tick();
        ex_valid    = 1'b0;
        dmem_rdata  = 32'h0BAD_CAFE;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("ldx0.rf_wr", {31'h0, rf_wr}, 32'h0);
        chk("ldx0.wdata", wdata, 32'h0BAD_CAFE);
        $display("txn load x0 wdata=0x%08h rf_wr=%0b", wdata, rf_wr);
        tick();

        // Reset in WAIT_MEM, then a late response
        drive(1'b1, 5'd3, 2'b01, 3'b010, 32'h0000_0080, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("rstw.busy", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw.busy0",  {31'h0, busy}, 32'h0);
        chk("rstw.ready",  {31'h0, ex_ready}, 32'h1);
        chk("rstw.rd",     {27'h0, rd}, 32'h0);
        chk("rstw.wdata",  wdata, 32'h0);
        chk("rstw.rf_wr",  {31'h0, rf_wr}, 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_8888;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstw.late_wr",    {31'h0, rf_wr}, 32'h0);
        chk("rstw.late_wdata", wdata, 32'h0);
        chk("rstw.late_busy",  {31'h0, busy}, 32'h0);
        chk("rstw.late_err",   {31'h0, load_err}, 32'h0);
        $display("txn reset mid-wait rf_wr=%0b busy=%0b", rf_wr, busy);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_unit.md
Name: rf_writeback_unit

Overview:
Drives the register-file write port (rf_wr, rd, wdata) from the final pipeline stage. It accepts retiring instructions from execute, selects the writeback source (ALU, load data, PC+4), and stalls on loads until the data-memory response arrives, with a bounded wait. Loads are aligned and extended per funct3. Outputs are registered on posedge clk so they are stable across the register file's negedge write.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before a load is aborted with an error (1..255).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ex_valid  input  1  execute stage presents a retiring instruction
ex_ready  output  1  unit can accept an instruction this cycle
ex_reg_wr  input  1  instruction writes a register
ex_rd  input  5  destination register
ex_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
ex_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ex_alu_result  input  32  ALU result; for loads, the byte address (bits[1:0] used for alignment)
ex_pc4  input  32  PC+4 of the instruction
dmem_rvalid  input  1  load data valid
dmem_rdata  input  32  raw memory word
rf_wr  output  1  register-file write enable
rd  output  5  register-file write address
wdata  output  32  register-file write data
busy  output  1  high while in WAIT_MEM
load_err  output  1  one-cycle pulse on load timeout or misaligned load

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, rf_wr 0, rd 0, wdata 0, busy 0, load_err 0, timeout counter 0.
- ex_ready = (state == IDLE). This output is combinational.
- An instruction is accepted when ex_valid && ex_ready.
- IDLE, accept, non-load (wb_sel != 01): on the next posedge, register rf_wr = ex_reg_wr && (ex_rd != 0), rd = ex_rd, and wdata as follows.
  - wb_sel 00 or 11: wdata = ex_alu_result.
  - wb_sel 10: wdata = ex_pc4.
  - Latency is 1 cycle. Back-to-back accepts are allowed every cycle.
- IDLE, accept, load (wb_sel == 01):
  - Capture rd, funct3, and addr[1:0].
  - Misaligned load (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0): no write, load_err pulses next cycle, stay in IDLE.
  - Otherwise go to WAIT_MEM and clear the counter.
  - rf_wr is 0 in the capture cycle.
- WAIT_MEM: busy=1, ex_ready=0.
  - If dmem_rvalid: next posedge registers rf_wr = (rd != 0) and rd, with wdata = the aligned load value, then returns to IDLE. The counter is irrelevant in this case.
  - Else, if counter == MEM_TIMEOUT-1: return to IDLE, rf_wr=0, load_err pulses.
  - Else the counter increments (8-bit saturating).
- Load data alignment, with byte = rdata >> (8*addr[1:0]):
  - LB: sign-extend byte[7:0].
  - LBU: zero-extend byte[7:0].
  - LH: sign-extend halfword at addr[1].
  - LHU: zero-extend halfword at addr[1].
  - LW: the full word.
  - Undefined funct3: treat as LW.
- dmem_rvalid in IDLE is ignored (stale response).
- rf_wr and load_err are high for exactly one cycle per event, never both at once.
- rd == 0 never asserts rf_wr, but rd and wdata are still updated.
- Reset mid-WAIT_MEM: immediate return to IDLE with all outputs cleared; a response arriving afterwards is ignored.
- Outputs change only on posedge or on reset; they stay stable through the following negedge.

Test Plan:
- ALU writeback: accept rd=5, wb_sel=00, alu=0xDEADBEEF → next cycle rf_wr=1, rd=5, wdata=0xDEADBEEF; the following cycle rf_wr=0.
- Load with wait: LB, addr=0x1003, rdata=0x80FF_0000 with rvalid 3 cycles later → busy=1 and ex_ready=0 for 3 cycles, then rf_wr=1, wdata=0xFFFFFF80. Repeat as LBU → wdata=0x00000080.
- Halfword and JAL: LHU addr=0x2002, rdata=0xBEEF1234 → wdata=0x0000BEEF. Accept wb_sel=10, pc4=0x104, rd=1 → wdata=0x104.
- Errors: LW addr=0x3001 → load_err pulse, no rf_wr, stays in IDLE. Load with no rvalid → load_err exactly MEM_TIMEOUT=15 cycles after entering WAIT_MEM; ex_ready returns high.
- x0 and back-to-back: three consecutive ALU accepts to rd=0, 7, 0 → rf_wr pattern 0, 1, 0, with rd updating each cycle.
- Reset: assert rst_n=0 in WAIT_MEM, then pulse rvalid after release → all outputs 0, state IDLE, no write.
